// File: rtl/sobel_grad_3x3.sv
// Sobel gradient stage: 3x3 window over streamed pixel columns, signed Gx/Gy,
// L1 magnitude and 4-bin direction, with border flagging and frame/line tags.
module sobel_grad_3x3 #(
    parameter int unsigned IMG_W = 514,
    parameter int unsigned IMG_H = 386
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_sof,
    input  logic [7:0]         tap_top,
    input  logic [7:0]         tap_mid,
    input  logic [7:0]         tap_bot,
    output logic               out_valid,
    output logic               out_sof,
    output logic               out_eol,
    output logic               out_border,
    output logic signed [10:0] out_gx,
    output logic signed [10:0] out_gy,
    output logic [10:0]        out_mag,
    output logic [1:0]         out_dir
);

    localparam int unsigned PW    = 8;
    localparam int unsigned SW    = 10;
    localparam int unsigned GW    = 11;
    localparam int unsigned PRODW = 16;
    localparam int unsigned CW    = $clog2(IMG_W);
    localparam int unsigned RW    = $clog2(IMG_H);

    // ---------------- S1: window and position tags ----------------
    logic [PW-1:0] win_q [3][3];
    logic [CW-1:0] col_q, col_d, col_tag;
    logic [RW-1:0] row_q, row_d, row_tag;
    logic          v1_q, sof1_q, eol1_q, bdr1_q;

    // col_q/row_q hold the position the next accepted column will take
    always_comb begin
        col_tag = in_sof ? '0 : col_q;
        row_tag = in_sof ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (in_valid) begin
            if (col_tag == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_tag == RW'(IMG_H - 1)) ? '0 : row_tag + RW'(1);
            end else begin
                col_d = col_tag + CW'(1);
                row_d = row_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            col_q  <= '0;
            row_q  <= '0;
            v1_q   <= 1'b0;
            sof1_q <= 1'b0;
            eol1_q <= 1'b0;
            bdr1_q <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            v1_q  <= in_valid;
            if (in_valid) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= tap_top;
                win_q[1][2] <= tap_mid;
                win_q[2][2] <= tap_bot;
                sof1_q      <= (col_tag == '0) && (row_tag == '0);
                eol1_q      <= (col_tag == CW'(IMG_W - 1));
                bdr1_q      <= (col_tag < CW'(2)) || (row_tag < RW'(2));
            end
        end
    end

    // ---------------- S2: Gx / Gy ----------------
    logic [SW-1:0]        sx_r_c, sx_l_c, sy_b_c, sy_t_c;
    logic signed [GW-1:0] gx_c, gy_c;
    logic signed [GW-1:0] gx2_q, gy2_q;
    logic                 v2_q, sof2_q, eol2_q, bdr2_q;

    // Weighted 1-2-1 sums are at most 1020, so the difference fits 11 bits signed
    always_comb begin
        sx_r_c = SW'(win_q[0][2]) + SW'({win_q[1][2], 1'b0}) + SW'(win_q[2][2]);
        sx_l_c = SW'(win_q[0][0]) + SW'({win_q[1][0], 1'b0}) + SW'(win_q[2][0]);
        sy_b_c = SW'(win_q[2][0]) + SW'({win_q[2][1], 1'b0}) + SW'(win_q[2][2]);
        sy_t_c = SW'(win_q[0][0]) + SW'({win_q[0][1], 1'b0}) + SW'(win_q[0][2]);
        gx_c   = signed'({1'b0, sx_r_c} - {1'b0, sx_l_c});
        gy_c   = signed'({1'b0, sy_b_c} - {1'b0, sy_t_c});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q   <= 1'b0;
            sof2_q <= 1'b0;
            eol2_q <= 1'b0;
            bdr2_q <= 1'b0;
            gx2_q  <= '0;
            gy2_q  <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                sof2_q <= sof1_q;
                eol2_q <= eol1_q;
                bdr2_q <= bdr1_q;
                gx2_q  <= gx_c;
                gy2_q  <= gy_c;
            end
        end
    end

    // ---------------- S3: magnitude, direction, outputs ----------------
    logic [GW-1:0]    ax_c, ay_c, mag_c;
    logic [PRODW-1:0] p32x_c, p32y_c, p13x_c, p13y_c;
    logic [1:0]       dir_c;

    // tan(22.5 deg) ~ 13/32; the two ratio tests pick the horizontal/vertical bins
    always_comb begin
        ax_c   = gx2_q[GW-1] ? GW'(-gx2_q) : GW'(gx2_q);
        ay_c   = gy2_q[GW-1] ? GW'(-gy2_q) : GW'(gy2_q);
        mag_c  = ax_c + ay_c;
        p32x_c = {ax_c, 5'b0};
        p32y_c = {ay_c, 5'b0};
        p13x_c = PRODW'(ax_c) * PRODW'(13);
        p13y_c = PRODW'(ay_c) * PRODW'(13);
        dir_c  = 2'd0;
        if (p32y_c <= p13x_c) begin
            dir_c = 2'd0;
        end else if (p13y_c >= p32x_c) begin
            dir_c = 2'd2;
        end else if (gx2_q[GW-1] == gy2_q[GW-1]) begin
            dir_c = 2'd1;
        end else begin
            dir_c = 2'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_eol    <= 1'b0;
            out_border <= 1'b0;
            out_gx     <= '0;
            out_gy     <= '0;
            out_mag    <= '0;
            out_dir    <= '0;
        end else begin
            out_valid <= v2_q;
            if (v2_q) begin
                out_sof    <= sof2_q;
                out_eol    <= eol2_q;
                out_border <= bdr2_q;
                out_gx     <= gx2_q;
                out_gy     <= gy2_q;
                out_mag    <= bdr2_q ? '0 : mag_c;
                out_dir    <= bdr2_q ? '0 : dir_c;
            end
        end
    end

endmodule

// File: tb/tb_sobel_grad_3x3.sv
// Self-checking bench for sobel_grad_3x3: table-driven window vectors, frame-tag
// sequences and a randomized stream scored against a linear-index reference model.
module tb_sobel_grad_3x3;

    localparam int TW = 34;
    localparam int TH = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_sof = 1'b0;
    logic [7:0]        tap_top = '0, tap_mid = '0, tap_bot = '0;
    logic              out_valid, out_sof, out_eol, out_border;
    logic signed [10:0] out_gx, out_gy;
    logic [10:0]       out_mag;
    logic [1:0]        out_dir;

    sobel_grad_3x3 #(.IMG_W(TW), .IMG_H(TH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .tap_top(tap_top), .tap_mid(tap_mid), .tap_bot(tap_bot),
        .out_valid(out_valid), .out_sof(out_sof), .out_eol(out_eol),
        .out_border(out_border), .out_gx(out_gx), .out_gy(out_gy),
        .out_mag(out_mag), .out_dir(out_dir)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        bit sof, eol, border;
        int gx, gy, mag, dir;
    } exp_t;

    typedef struct {
        int px [3][3];
        int gx, gy, mag, dir;
    } vec_t;

    exp_t q[$];
    exp_t last_exp;
    exp_t dut_last;
    int   hist [3][3];
    int   lin;
    int   k;
    int   n_cmp, n_bad;
    int   obs_cnt, obs_bdr, obs_eol, obs_sof;
    vec_t vt [7];

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (step %0d)", name, act, exp, k);
        end
    endtask

    function automatic int ref_dir(input int gx, input int gy);
        int ax, ay;
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        if (32 * ay <= 13 * ax) return 0;
        if (13 * ay >= 32 * ax) return 2;
        if ((gx > 0) == (gy > 0)) return 1;
        return 3;
    endfunction

    task automatic model_reset();
        q.delete();
        lin      = 0;
        last_exp = '{default: 0};
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) hist[r][c] = 0;
    endtask

    task automatic model_accept(input bit s, input int t, input int m, input int b);
        exp_t e;
        int row, col, ax, ay;
        if (s) lin = 0;
        row = lin / TW;
        col = lin % TW;
        for (int r = 0; r < 3; r++) begin
            hist[r][0] = hist[r][1];
            hist[r][1] = hist[r][2];
        end
        hist[0][2] = t; hist[1][2] = m; hist[2][2] = b;
        e.due    = k + 3;
        e.gx     = (hist[0][2] + 2 * hist[1][2] + hist[2][2]) - (hist[0][0] + 2 * hist[1][0] + hist[2][0]);
        e.gy     = (hist[2][0] + 2 * hist[2][1] + hist[2][2]) - (hist[0][0] + 2 * hist[0][1] + hist[0][2]);
        e.border = (col < 2) || (row < 2);
        e.sof    = (lin == 0);
        e.eol    = (col == TW - 1);
        ax       = (e.gx < 0) ? -e.gx : e.gx;
        ay       = (e.gy < 0) ? -e.gy : e.gy;
        e.mag    = e.border ? 0 : ax + ay;
        e.dir    = e.border ? 0 : ref_dir(e.gx, e.gy);
        q.push_back(e);
        lin = (lin + 1) % (TW * TH);
    endtask

    task automatic check_outputs();
        if (q.size() > 0 && q[0].due == k) begin
            exp_t e;
            e = q.pop_front();
            chk("out_valid", out_valid, 1);
            chk("sof", out_sof, e.sof);
            chk("eol", out_eol, e.eol);
            chk("border", out_border, e.border);
            chk("gx", out_gx, e.gx);
            chk("gy", out_gy, e.gy);
            chk("mag", out_mag, e.mag);
            chk("dir", out_dir, e.dir);
            last_exp = e;
        end else begin
            chk("out_valid_idle", out_valid, 0);
            chk("hold", {out_sof, out_eol, out_border, out_gx, out_gy, out_mag, out_dir},
                {last_exp.sof, last_exp.eol, last_exp.border, 11'(last_exp.gx),
                 11'(last_exp.gy), 11'(last_exp.mag), 2'(last_exp.dir)});
        end
        if (out_valid === 1'b1) begin
            dut_last.sof    = out_sof;
            dut_last.eol    = out_eol;
            dut_last.border = out_border;
            dut_last.gx     = int'(out_gx);
            dut_last.gy     = int'(out_gy);
            dut_last.mag    = int'(out_mag);
            dut_last.dir    = int'(out_dir);
            obs_cnt++;
            obs_bdr += int'(out_border);
            obs_eol += int'(out_eol);
            obs_sof += int'(out_sof);
        end
    endtask

    // One cycle: check what the DUT shows now, then drive the next inputs
    task automatic step(input bit r, input bit v, input bit s,
                        input int t, input int m, input int b);
        @(negedge clk);
        k++;
        check_outputs();
        rst      = r;
        in_valid = v;
        in_sof   = s;
        tap_top  = 8'(t);
        tap_mid  = 8'(m);
        tap_bot  = 8'(b);
        if (r) model_reset();
        else if (v) model_accept(s, t, m, b);
    endtask

    task automatic rnd_col(input bit s);
        step(0, 1, s, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic set_vec(input int i, input int r0 [3], input int r1 [3], input int r2 [3],
                           input int gx, input int gy, input int mag, input int dir);
        for (int c = 0; c < 3; c++) begin
            vt[i].px[0][c] = r0[c];
            vt[i].px[1][c] = r1[c];
            vt[i].px[2][c] = r2[c];
        end
        vt[i].gx = gx; vt[i].gy = gy; vt[i].mag = mag; vt[i].dir = dir;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; k = 0;
        obs_cnt = 0; obs_bdr = 0; obs_eol = 0; obs_sof = 0;
        dut_last = '{default: 0};
        model_reset();

        set_vec(0, '{0, 0, 100}, '{0, 0, 100}, '{0, 0, 100}, 400, 0, 400, 0);
        set_vec(1, '{0, 0, 0}, '{0, 0, 0}, '{100, 100, 100}, 0, 400, 400, 2);
        set_vec(2, '{100, 100, 100}, '{0, 0, 0}, '{0, 0, 0}, 0, -400, 400, 2);
        set_vec(3, '{255, 0, 0}, '{255, 0, 0}, '{255, 0, 0}, -1020, 0, 1020, 0);
        set_vec(4, '{0, 0, 0}, '{0, 0, 100}, '{0, 100, 100}, 300, 300, 600, 1);
        set_vec(5, '{0, 0, 0}, '{100, 0, 0}, '{100, 100, 0}, -300, 300, 600, 3);
        set_vec(6, '{50, 50, 50}, '{50, 50, 50}, '{50, 50, 50}, 0, 0, 0, 0);

        // Reset state
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_fields", {out_sof, out_eol, out_border, out_gx, out_gy, out_mag, out_dir}, 0);

        // Window vectors at interior positions, first one at row 5 col 10
        for (int i = 0; i < 7; i++) begin
            while (!((i == 0) ? (lin == 5 * TW + 8) : (lin % TW == 8 && lin / TW >= 2)))
                rnd_col(0);
            for (int c = 0; c < 3; c++) step(0, 1, 0, vt[i].px[0][c], vt[i].px[1][c], vt[i].px[2][c]);
            idle(3);
            chk($sformatf("vec%0d_gx", i), dut_last.gx, vt[i].gx);
            chk($sformatf("vec%0d_gy", i), dut_last.gy, vt[i].gy);
            chk($sformatf("vec%0d_mag", i), dut_last.mag, vt[i].mag);
            chk($sformatf("vec%0d_dir", i), dut_last.dir, vt[i].dir);
            chk($sformatf("vec%0d_border", i), dut_last.border, 0);
        end

        // Full frame, one column every other cycle
        idle(4);
        obs_cnt = 0; obs_bdr = 0; obs_eol = 0; obs_sof = 0;
        for (int i = 0; i < TW * TH; i++) begin
            rnd_col(i == 0);
            idle(1);
        end
        idle(3);
        chk("frame_count", obs_cnt, TW * TH);
        chk("frame_border", obs_bdr, 2 * TW + 2 * (TH - 2));
        chk("frame_eol", obs_eol, TH);
        chk("frame_sof", obs_sof, 1);
        rnd_col(0);
        idle(3);
        chk("wrap_sof", dut_last.sof, 1);
        chk("wrap_border", dut_last.border, 1);

        // Resync with in_sof at row 7 col 20, previous columns still in flight
        while (lin != 7 * TW + 20) rnd_col(0);
        rnd_col(1);
        idle(3);
        chk("resync_sof", dut_last.sof, 1);
        chk("resync_border", dut_last.border, 1);
        chk("resync_mag", dut_last.mag, 0);
        for (int i = 0; i < 2 * TW + 5; i++) rnd_col(0);
        idle(3);
        chk("resync_follow_border", dut_last.border, 0);

        // Reset with results in flight
        for (int i = 0; i < 5; i++) rnd_col(0);
        step(1, 0, 0, 0, 0, 0);
        idle(3);
        chk("midrst_fields", {out_sof, out_eol, out_border, out_gx, out_gy, out_mag, out_dir}, 0);
        step(0, 1, 0, 200, 10, 90);
        idle(3);
        chk("midrst_sof", dut_last.sof, 1);
        chk("midrst_border", dut_last.border, 1);
        chk("midrst_dir", dut_last.dir, 0);

        // Randomized stream with gaps, sporadic in_sof and resets
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 400) == 0) begin
                step(1, 0, 0, 0, 0, 0);
            end else if ($urandom_range(0, 2) != 0) begin
                rnd_col($urandom_range(0, 60) == 0);
            end else begin
                idle(1);
            end
        end
        idle(4);
        chk("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
